// File: rtl/writeback_unit_if.sv
// Execute/writeback bus: completed-instruction handoff, operand read ports,
// branch-condition query and committed architectural status.
interface writeback_unit_if #(
    parameter int DW = 16,
    parameter int AW = 3
);
    logic          ex_valid;
    logic [AW-1:0] ex_rd;
    logic [DW-1:0] ex_res;
    logic [3:0]    ex_szcv;
    logic          ex_reg_we;
    logic          ex_flag_we;
    logic          flush;
    logic [AW-1:0] ra_addr;
    logic [AW-1:0] rb_addr;
    logic [DW-1:0] ra_data;
    logic [DW-1:0] rb_data;
    logic [2:0]    br_cond;
    logic          br_taken;
    logic [3:0]    flags;
    logic          pend_valid;
    logic [15:0]   retire_count;

    modport master (
        output ex_valid, ex_rd, ex_res, ex_szcv, ex_reg_we, ex_flag_we,
        output flush, ra_addr, rb_addr, br_cond,
        input  ra_data, rb_data, br_taken, flags, pend_valid, retire_count
    );

    modport slave (
        input  ex_valid, ex_rd, ex_res, ex_szcv, ex_reg_we, ex_flag_we,
        input  flush, ra_addr, rb_addr, br_cond,
        output ra_data, rb_data, br_taken, flags, pend_valid, retire_count
    );
endinterface

// File: rtl/writeback_unit.sv
// Register file and SZCV condition codes behind a one-deep execute-to-writeback
// register, with read bypass from the pending entry and branch evaluation.
module writeback_unit #(
    parameter int DW   = 16,
    parameter int NREG = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    writeback_unit_if.slave   bus
);
    localparam int AW = $clog2(NREG);

    logic          pend_valid_q, pend_valid_d;
    logic [AW-1:0] pend_rd_q, pend_rd_d;
    logic [DW-1:0] pend_res_q, pend_res_d;
    logic [3:0]    pend_szcv_q, pend_szcv_d;
    logic          pend_reg_we_q, pend_reg_we_d;
    logic          pend_flag_we_q, pend_flag_we_d;
    logic [DW-1:0] regfile_q [NREG];
    logic [DW-1:0] regfile_d [NREG];
    logic [3:0]    flags_q, flags_d;
    logic [15:0]   retire_q, retire_d;

    logic          commit_s;
    logic          reg_byp_s;
    logic [3:0]    eff_flags_s;
    logic          br_s;

    // The pending entry is live for bypass exactly when it is about to commit.
    assign commit_s    = pend_valid_q & ~bus.flush;
    assign reg_byp_s   = commit_s & pend_reg_we_q;
    assign eff_flags_s = (commit_s & pend_flag_we_q) ? pend_szcv_q : flags_q;

    // Next-state for the stage register and the architectural state it commits into.
    always_comb begin
        pend_valid_d   = bus.ex_valid;
        pend_rd_d      = bus.ex_valid ? bus.ex_rd      : pend_rd_q;
        pend_res_d     = bus.ex_valid ? bus.ex_res     : pend_res_q;
        pend_szcv_d    = bus.ex_valid ? bus.ex_szcv    : pend_szcv_q;
        pend_reg_we_d  = bus.ex_valid ? bus.ex_reg_we  : pend_reg_we_q;
        pend_flag_we_d = bus.ex_valid ? bus.ex_flag_we : pend_flag_we_q;
        for (int i = 0; i < NREG; i++) begin
            regfile_d[i] = (reg_byp_s && (pend_rd_q == i[AW-1:0])) ? pend_res_q : regfile_q[i];
        end
        flags_d  = (commit_s && pend_flag_we_q) ? pend_szcv_q : flags_q;
        retire_d = commit_s ? (retire_q + 16'd1) : retire_q;
    end

    // State registers; reset drops any pending entry without committing it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_valid_q   <= 1'b0;
            pend_rd_q      <= '0;
            pend_res_q     <= '0;
            pend_szcv_q    <= 4'b0000;
            pend_reg_we_q  <= 1'b0;
            pend_flag_we_q <= 1'b0;
            regfile_q      <= '{default: '0};
            flags_q        <= 4'b0000;
            retire_q       <= 16'h0000;
        end else begin
            pend_valid_q   <= pend_valid_d;
            pend_rd_q      <= pend_rd_d;
            pend_res_q     <= pend_res_d;
            pend_szcv_q    <= pend_szcv_d;
            pend_reg_we_q  <= pend_reg_we_d;
            pend_flag_we_q <= pend_flag_we_d;
            regfile_q      <= regfile_d;
            flags_q        <= flags_d;
            retire_q       <= retire_d;
        end
    end

    // Branch condition decode on {S,Z,C,V}; LT is S xor V.
    always_comb begin
        br_s = 1'b0;
        case (bus.br_cond)
            3'b000:  br_s = eff_flags_s[2];
            3'b001:  br_s = eff_flags_s[3] ^ eff_flags_s[0];
            3'b010:  br_s = eff_flags_s[2] | (eff_flags_s[3] ^ eff_flags_s[0]);
            3'b011:  br_s = ~eff_flags_s[2];
            3'b100:  br_s = 1'b1;
            default: br_s = 1'b0;
        endcase
    end

    assign bus.ra_data = (reg_byp_s && (pend_rd_q == bus.ra_addr)) ? pend_res_q : regfile_q[bus.ra_addr];
    assign bus.rb_data = (reg_byp_s && (pend_rd_q == bus.rb_addr)) ? pend_res_q : regfile_q[bus.rb_addr];
    assign bus.br_taken     = br_s;
    assign bus.flags        = flags_q;
    assign bus.pend_valid   = pend_valid_q;
    assign bus.retire_count = retire_q;
endmodule

// File: tb/tb_writeback_unit.sv
// Directed and randomized bench for writeback_unit against a queue-based
// architectural model (at most one in-flight entry, committed on the next edge).
module tb_writeback_unit;
    logic clk;
    logic rst_n;
    int   tests;
    int   fails;

    writeback_unit_if #(.DW(16), .AW(3)) bus ();

    writeback_unit #(.DW(16), .NREG(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  rd;
        logic [15:0] res;
        logic [3:0]  szcv;
        logic        rwe;
        logic        fwe;
    } ent_t;

    logic [15:0] reg_m [8];
    logic [3:0]  flags_m;
    logic [15:0] retire_m;
    ent_t        pq [$];

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] exp_read(input logic [2:0] addr);
        if (pq.size() != 0 && pq[0].rwe && !bus.flush && pq[0].rd == addr) return pq[0].res;
        return reg_m[addr];
    endfunction

    function automatic logic exp_branch(input logic [2:0] cond);
        logic [3:0] f;
        logic s, z, v;
        f = flags_m;
        if (pq.size() != 0 && pq[0].fwe && !bus.flush) f = pq[0].szcv;
        s = f[3]; z = f[2]; v = f[0];
        case (cond)
            3'd0:    return z;
            3'd1:    return s != v;
            3'd2:    return z || (s != v);
            3'd3:    return !z;
            3'd4:    return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    task automatic check_model(input string tag);
        chk({tag, ".ra"},     bus.ra_data,            exp_read(bus.ra_addr));
        chk({tag, ".rb"},     bus.rb_data,            exp_read(bus.rb_addr));
        chk({tag, ".br"},     {15'd0, bus.br_taken},  {15'd0, exp_branch(bus.br_cond)});
        chk({tag, ".flags"},  {12'd0, bus.flags},     {12'd0, flags_m});
        chk({tag, ".pend"},   {15'd0, bus.pend_valid}, {15'd0, (pq.size() != 0)});
        chk({tag, ".retire"}, bus.retire_count,       retire_m);
    endtask

    task automatic model_reset();
        for (int i = 0; i < 8; i++) reg_m[i] = 16'h0000;
        flags_m  = 4'b0000;
        retire_m = 16'h0000;
        pq.delete();
    endtask

    task automatic tick();
        ent_t e;
        if (rst_n) begin
            if (pq.size() != 0 && !bus.flush) begin
                e = pq[0];
                if (e.rwe) reg_m[e.rd] = e.res;
                if (e.fwe) flags_m = e.szcv;
                retire_m = retire_m + 16'd1;
            end
            pq.delete();
            if (bus.ex_valid) begin
                e.rd = bus.ex_rd; e.res = bus.ex_res; e.szcv = bus.ex_szcv;
                e.rwe = bus.ex_reg_we; e.fwe = bus.ex_flag_we;
                pq.push_back(e);
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drv(input logic v, input logic [2:0] rd, input logic [15:0] res,
                       input logic [3:0] szcv, input logic rwe, input logic fwe, input logic fl);
        bus.ex_valid = v; bus.ex_rd = rd; bus.ex_res = res; bus.ex_szcv = szcv;
        bus.ex_reg_we = rwe; bus.ex_flag_we = fwe; bus.flush = fl;
    endtask

    initial begin
        tests = 0;
        fails = 0;
        rst_n = 1'b0;
        drv(1'b0, 3'd0, 16'h0000, 4'b0000, 1'b0, 1'b0, 1'b0);
        bus.ra_addr = 3'd3; bus.rb_addr = 3'd5; bus.br_cond = 3'd0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        chk("reset.ra", bus.ra_data, 16'h0000);
        chk("reset.retire", bus.retire_count, 16'h0000);
        rst_n = 1'b1;
        #1;
        check_model("post_reset");

        // Write then bypass then committed read of r3.
        drv(1'b1, 3'd3, 16'h1234, 4'b0000, 1'b1, 1'b0, 1'b0);
        tick();
        drv(1'b0, 3'd0, 16'h0000, 4'b0000, 1'b0, 1'b0, 1'b0);
        #1;
        chk("bypass.ra", bus.ra_data, 16'h1234);
        chk("bypass.retire", bus.retire_count, 16'h0000);
        check_model("bypass");
        tick();
        chk("commit.ra", bus.ra_data, 16'h1234);
        chk("commit.retire", bus.retire_count, 16'h0001);

        // CMP: flags only, branch BE sees the pending Z.
        bus.rb_addr = 3'd0;
        drv(1'b1, 3'd0, 16'hFFFF, 4'b0100, 1'b0, 1'b1, 1'b0);
        tick();
        drv(1'b0, 3'd0, 16'h0000, 4'b0000, 1'b0, 1'b0, 1'b0);
        bus.br_cond = 3'd0;
        #1;
        chk("cmp.be", {15'd0, bus.br_taken}, 16'h0001);
        chk("cmp.flags_not_yet", {12'd0, bus.flags}, 16'h0000);
        chk("cmp.r0", bus.rb_data, 16'h0000);
        tick();
        chk("cmp.flags", {12'd0, bus.flags}, 16'h0004);

        // Branch decode from pending S=1,V=0 then S=1,V=1.
        drv(1'b1, 3'd0, 16'h0000, 4'b1000, 1'b0, 1'b1, 1'b0);
        tick();
        drv(1'b0, 3'd0, 16'h0000, 4'b0000, 1'b0, 1'b0, 1'b0);
        bus.br_cond = 3'd1; #1; chk("br.blt", {15'd0, bus.br_taken}, 16'h0001);
        bus.br_cond = 3'd2; #1; chk("br.ble", {15'd0, bus.br_taken}, 16'h0001);
        bus.br_cond = 3'd3; #1; chk("br.bne", {15'd0, bus.br_taken}, 16'h0001);
        bus.br_cond = 3'd0; #1; chk("br.be",  {15'd0, bus.br_taken}, 16'h0000);
        bus.br_cond = 3'd6; #1; chk("br.never", {15'd0, bus.br_taken}, 16'h0000);
        drv(1'b1, 3'd0, 16'h0000, 4'b1001, 1'b0, 1'b1, 1'b0);
        tick();
        drv(1'b0, 3'd0, 16'h0000, 4'b0000, 1'b0, 1'b0, 1'b0);
        bus.br_cond = 3'd1; #1; chk("br.blt_v", {15'd0, bus.br_taken}, 16'h0000);
        tick();

        // Flush kills the pending write to r5.
        drv(1'b1, 3'd5, 16'hABCD, 4'b0000, 1'b1, 1'b0, 1'b0);
        bus.rb_addr = 3'd5;
        tick();
        drv(1'b0, 3'd0, 16'h0000, 4'b0000, 1'b0, 1'b0, 1'b1);
        #1;
        chk("flush.rb", bus.rb_data, 16'h0000);
        check_model("flush");
        tick();
        bus.flush = 1'b0;
        #1;
        chk("flush.r5", bus.rb_data, 16'h0000);
        chk("flush.retire", bus.retire_count, 16'h0004);

        // Back-to-back writes to r1.
        bus.ra_addr = 3'd1;
        for (int k = 1; k <= 3; k++) begin
            drv(1'b1, 3'd1, 16'(k), 4'b0000, 1'b1, 1'b0, 1'b0);
            tick();
            check_model("b2b");
        end
        drv(1'b0, 3'd0, 16'h0000, 4'b0000, 1'b0, 1'b0, 1'b0);
        tick();
        chk("b2b.r1", bus.ra_data, 16'h0003);

        // Randomized traffic against the model.
        for (int n = 0; n < 400; n++) begin
            drv(1'($urandom), 3'($urandom), 16'($urandom), 4'($urandom),
                1'($urandom), 1'($urandom), ($urandom_range(0, 7) == 0));
            bus.ra_addr = 3'($urandom);
            bus.rb_addr = 3'($urandom);
            bus.br_cond = 3'($urandom);
            #1;
            check_model("rand");
            tick();
        end

        // Retire counter wrap.
        drv(1'b1, 3'd0, 16'h0000, 4'b0000, 1'b0, 1'b0, 1'b0);
        for (int n = 0; n < 70000 && retire_m != 16'hFFFF; n++) tick();
        chk("wrap.ffff", bus.retire_count, 16'hFFFF);
        tick();
        chk("wrap.zero", bus.retire_count, 16'h0000);
        check_model("wrap");

        // Asynchronous reset with an entry pending: no commit, immediate clear.
        drv(1'b1, 3'd2, 16'h5A5A, 4'b1111, 1'b1, 1'b1, 1'b0);
        bus.ra_addr = 3'd2;
        tick();
        drv(1'b0, 3'd0, 16'h0000, 4'b0000, 1'b0, 1'b0, 1'b0);
        #1;
        rst_n = 1'b0;
        #1;
        model_reset();
        chk("arst.ra", bus.ra_data, 16'h0000);
        chk("arst.flags", {12'd0, bus.flags}, 16'h0000);
        chk("arst.retire", bus.retire_count, 16'h0000);
        chk("arst.pend", {15'd0, bus.pend_valid}, 16'h0000);
        tick();
        rst_n = 1'b1;
        #1;
        tick();
        chk("arst.no_commit", bus.retire_count, 16'h0000);
        check_model("arst");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/writeback_unit.md
Name: writeback_unit

Overview:
Register-file and condition-code stage for the 16-bit SIMPLE datapath.
- Supplies the two 16-bit operands that feed the ALU.
- Captures the ALU's result and SZCV flags in a one-deep execute-to-writeback register, then commits them one cycle later.
- Provides read bypass from the pending entry and branch-condition evaluation.
- Keeps a retired-instruction counter.

Parameters:
DW, 16, data/register width
NREG, 8, number of general registers (r0..r7); address width 3

Ports:
clk  in  1  clock
rst_n  in  1  reset; asynchronous, active-low
ex_valid  in  1  execute stage presents a completed instruction this cycle
ex_rd  in  3  destination register
ex_res  in  16  ALU result
ex_szcv  in  4  ALU flags {S,Z,C,V}
ex_reg_we  in  1  result is written to ex_rd (0 for CMP, stores, branches)
ex_flag_we  in  1  flags are updated (arithmetic, logic, shift, CMP)
flush  in  1  kill the pending (uncommitted) entry
ra_addr  in  3  read port A address (ALU operand a)
rb_addr  in  3  read port B address (ALU operand b)
ra_data  out  16  read port A data
rb_data  out  16  read port B data
br_cond  in  3  branch condition: 000 BE, 001 BLT, 010 BLE, 011 BNE, 100 always, others never
br_taken  out  1  condition satisfied
flags  out  4  committed SZCV
pend_valid  out  1  an entry is pending in the writeback register
retire_count  out  16  committed instruction count

Behaviour:
- Reset (rst_n low, asynchronous):
  - all 8 registers = 0, flags = 0000, pend_valid = 0, retire_count = 0.
  - Outputs follow immediately, without waiting for a clock edge.
  - Reset asserted mid-operation discards the pending entry with no commit.
- Stage register (pend_*): at each rising edge, pend_valid <= ex_valid; pend_rd/res/szcv/reg_we/flag_we <= ex_* when ex_valid=1, else hold.
- Commit: at a rising edge where pend_valid=1 and flush=0:
  - regfile[pend_rd] <= pend_res if pend_reg_we.
  - flags <= pend_szcv if pend_flag_we.
  - retire_count <= retire_count+1, wrapping FFFF->0000.
- Latency: ex_valid sampled at edge N; visible through bypass during cycle N+1; architectural state updated at edge N+1.
- Flush: flush=1 at an edge suppresses commit of the pending entry. Loading of a new ex_valid entry in the same cycle is unaffected.
- Back-to-back: a new entry loads at the same edge the previous one commits; no bubble and no stall.
- Read ports are combinational. Priority for each port:
  1. pend_valid & pend_reg_we & ~flush & pend_rd==addr -> pend_res
  2. otherwise regfile[addr]
  - Both ports may read the same register.
  - ex_* is not bypassed; execute-stage forwarding is handled upstream.
- Effective flags F:
  - F = pend_szcv when pend_valid & pend_flag_we & ~flush, else flags.
  - br_taken is computed from F:
    - BE: Z
    - BLT: S^V
    - BLE: Z | (S^V)
    - BNE: ~Z
    - always: 1
    - others: 0
- flags output shows committed flags only, never bypassed values.
- No read-only r0: all 8 registers are writable.
- All widths are exact; no sign extension inside the block.

Test Plan:
- Reset: hold rst_n=0 mid-run -> ra_data=rb_data=0000, flags=0000, retire_count=0 immediately; first edge after release performs no commit.
- Write/bypass: cycle 0 ex_valid=1, rd=3, res=1234, reg_we=1. Cycle 1 ra_addr=3 -> ra_data=1234 via bypass, regfile[3] still old. Cycle 2 -> ra_data=1234 from regfile, retire_count=1.
- CMP flags only: ex_reg_we=0, flag_we=1, szcv=0100 -> registers unchanged. Next cycle br_cond=000 -> br_taken=1; after commit flags=0100.
- Branch decode: pending szcv=1000 with flag_we=1 -> BLT=1, BLE=1, BNE=1, BE=0. szcv=1001 -> BLT=0.
- Flush: pend rd=5 res=ABCD, flush=1 -> rb_addr=5 returns old value during flush; regfile[5] unchanged; retire_count not incremented.
- Back-to-back and wrap:
  - three consecutive ex_valid writes to r1 (0001, 0002, 0003) -> r1=0003 after the last commit.
  - retire_count preset via 65535 commits -> wraps to 0000.
